// File: rtl/tdc_uart_streamer_pkg.sv
// Shared constants, frame state encoding and checksum helpers for tdc_uart_streamer.
// Optional feature macro: TDC_STREAM_POPCOUNT_EN adds a POP byte ahead of CHK.
package tdc_stream_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef TDC_STREAM_POPCOUNT_EN
    localparam logic [3:0] FRAME_BYTES = 4'd12;
`else
    localparam logic [3:0] FRAME_BYTES = 4'd11;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } stream_state_t;

    // XOR of SEQ with all eight snapshot bytes; SYNC never takes part.
    function automatic logic [7:0] xor_fold(input logic [7:0] seq, input logic [63:0] data);
        logic [7:0] acc;
        acc = seq;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ data[8*i +: 8];
        end
        return acc;
    endfunction

`ifdef TDC_STREAM_POPCOUNT_EN
    function automatic logic [7:0] popcount64(input logic [63:0] data);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {7'd0, data[i]};
        end
        return cnt;
    endfunction
`endif

endpackage

// File: rtl/tdc_uart_streamer_uart_tx_8n1.sv
// Byte-wide UART 8N1 transmitter with a valid/ready handshake.
// Ready is also raised in the last stop-bit cycle so back-to-back bytes have no idle gap.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] clk_cnt_r;
    logic [3:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             active_r;
    logic             tx_r;
    logic             bit_end_s;
    logic             stop_end_s;

    // bit_idx 0 = start, 1..8 = data, 9 = stop
    assign bit_end_s  = (clk_cnt_r == CNT_MAX);
    assign stop_end_s = active_r && (bit_idx_r == 4'd9) && bit_end_s;
    assign tx_ready   = !active_r || stop_end_s;
    assign tx         = tx_r;

    // Bit timing, shift register and line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_r <= CNT_ZERO;
            bit_idx_r <= 4'd0;
            shift_r   <= 8'd0;
            active_r  <= 1'b0;
            tx_r      <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            clk_cnt_r <= CNT_ZERO;
            bit_idx_r <= 4'd0;
            shift_r   <= tx_data;
            active_r  <= 1'b1;
            tx_r      <= 1'b0;
        end else if (stop_end_s) begin
            clk_cnt_r <= CNT_ZERO;
            bit_idx_r <= 4'd0;
            active_r  <= 1'b0;
            tx_r      <= 1'b1;
        end else if (active_r) begin
            if (bit_end_s) begin
                clk_cnt_r <= CNT_ZERO;
                bit_idx_r <= bit_idx_r + 4'd1;
                if (bit_idx_r == 4'd8) begin
                    tx_r <= 1'b1;
                end else begin
                    tx_r    <= shift_r[0];
                    shift_r <= {1'b0, shift_r[7:1]};
                end
            end else begin
                clk_cnt_r <= clk_cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/tdc_uart_streamer.sv
// Freezes a 64-bit TDC snapshot on data_valid and streams it as a SYNC/SEQ/D0..D7/CHK UART frame.
// Build macro TDC_STREAM_POPCOUNT_EN inserts a POP (ones count) byte before CHK.
module tdc_uart_streamer
    import tdc_stream_pkg::*;
#(
    parameter int CLK_HZ = 240_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] tdc_data,
    input  logic        data_valid,
    input  logic        enable,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    stream_state_t state_r;
    stream_state_t state_s;
    logic [63:0]   snap_r;
    logic [7:0]    seq_r;
    logic [7:0]    drop_r;
    logic [3:0]    idx_r;
    logic          busy_r;

    logic [7:0]    tx_byte_s;
    logic [7:0]    chk_s;
    logic          tx_valid_s;
    logic          tx_ready_s;
    logic          tx_line_s;
    logic          capture_s;
    logic          drop_s;
    logic          accept_s;
    logic          last_done_s;

`ifdef TDC_STREAM_POPCOUNT_EN
    logic [7:0]    pop_s;
    assign pop_s = popcount64(snap_r);
    assign chk_s = xor_fold(seq_r, snap_r) ^ pop_s;
`else
    assign chk_s = xor_fold(seq_r, snap_r);
`endif

    assign capture_s   = data_valid && enable && (state_r == IDLE);
    assign drop_s      = data_valid && enable && (state_r != IDLE);
    assign tx_valid_s  = (state_r == SEND) && (idx_r < FRAME_BYTES);
    assign accept_s    = tx_valid_s && tx_ready_s;
    // Once every byte is handed over, the next ready marks the end of the final stop bit.
    assign last_done_s = (state_r == SEND) && (idx_r == FRAME_BYTES) && tx_ready_s;

    assign uart_tx  = tx_line_s;
    assign busy     = busy_r;
    assign drop_cnt = drop_r;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: state_s = SEND;
            SEND: begin
                if (last_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Byte selection for the current frame position.
    always_comb begin
        case (idx_r)
            4'd0:    tx_byte_s = SYNC_BYTE;
            4'd1:    tx_byte_s = seq_r;
            4'd2:    tx_byte_s = snap_r[7:0];
            4'd3:    tx_byte_s = snap_r[15:8];
            4'd4:    tx_byte_s = snap_r[23:16];
            4'd5:    tx_byte_s = snap_r[31:24];
            4'd6:    tx_byte_s = snap_r[39:32];
            4'd7:    tx_byte_s = snap_r[47:40];
            4'd8:    tx_byte_s = snap_r[55:48];
            4'd9:    tx_byte_s = snap_r[63:56];
`ifdef TDC_STREAM_POPCOUNT_EN
            4'd10:   tx_byte_s = pop_s;
`endif
            default: tx_byte_s = chk_s;
        endcase
    end

    // Sequencer state, snapshot, byte index, SEQ and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            snap_r  <= 64'd0;
            idx_r   <= 4'd0;
            seq_r   <= 8'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            if (capture_s) begin
                snap_r <= tdc_data;
            end
            if (state_r == LOAD) begin
                idx_r <= 4'd0;
            end else if (accept_s) begin
                idx_r <= idx_r + 4'd1;
            end
            if (last_done_s) begin
                seq_r <= seq_r + 8'd1;
            end
        end
    end

    // Saturating count of captures lost while a frame is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= 8'd0;
        end else if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_byte_s),
        .tx_valid (tx_valid_s),
        .tx_ready (tx_ready_s),
        .tx       (tx_line_s)
    );

endmodule

// File: tb/tb_tdc_uart_streamer.sv
// Directed bench for tdc_uart_streamer at 4 clocks per bit; a second instance at 2 clocks per bit covers SEQ wrap.
module tb_tdc_uart_streamer;

`ifdef TDC_STREAM_POPCOUNT_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tdc_data;
    logic        data_valid;
    logic        data_valid_w;
    logic        enable;
    logic        uart_tx;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        uart_tx_w;
    logic        busy_w;
    logic [7:0]  drop_cnt_w;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rx_q[$];
    logic       stop_q[$];
    int         rst_cnt = 0;
    int         busy_run = 0;
    int         busy_last = 0;

    tdc_uart_streamer #(.CLK_HZ(4_000_000), .BAUD(1_000_000)) dut (
        .clk(clk), .rst(rst), .tdc_data(tdc_data), .data_valid(data_valid), .enable(enable),
        .uart_tx(uart_tx), .busy(busy), .drop_cnt(drop_cnt)
    );

    tdc_uart_streamer #(.CLK_HZ(2_000_000), .BAUD(1_000_000)) dut_w (
        .clk(clk), .rst(rst), .tdc_data(tdc_data), .data_valid(data_valid_w), .enable(enable),
        .uart_tx(uart_tx_w), .busy(busy_w), .drop_cnt(drop_cnt_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else begin
            if (busy_run != 0) busy_last <= busy_run;
            busy_run <= 0;
        end
    end

    // Decode the main line at mid-bit; bytes interrupted by reset are discarded.
    initial begin : rx_monitor
        logic [7:0] b;
        int r0;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                r0 = rst_cnt;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                if (rst_cnt == r0) begin
                    rx_q.push_back(b);
                    stop_q.push_back(uart_tx);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] exp_frame(input logic [7:0] seq, input logic [63:0] d);
        logic [95:0] f;
        logic [7:0]  chk;
        f = 96'd0;
        chk = seq;
        f[7:0] = 8'hA5;
        f[15:8] = seq;
        for (int k = 0; k < 8; k++) begin
            f[8*(k+2) +: 8] = d[8*k +: 8];
            chk = chk ^ d[8*k +: 8];
        end
`ifdef TDC_STREAM_POPCOUNT_EN
        begin
            logic [7:0] pop;
            pop = 8'd0;
            for (int k = 0; k < 64; k++) pop = pop + {7'd0, d[k]};
            f[87:80] = pop;
            f[95:88] = chk ^ pop;
        end
`else
        f[87:80] = chk;
`endif
        return f;
    endfunction

    task automatic wait_bytes(input int n, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " rx count"}, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_frame(input string tag, input logic [7:0] seq, input logic [63:0] d);
        logic [95:0] f;
        logic [7:0]  b;
        logic        stops;
        f = exp_frame(seq, d);
        stops = 1'b1;
        wait_bytes(NB, tag);
        if (rx_q.size() >= NB) begin
            for (int i = 0; i < NB; i++) begin
                b = rx_q.pop_front();
                stops = stops & stop_q.pop_front();
                check($sformatf("%s byte%0d", tag, i), 64'(b), 64'(f[8*i +: 8]));
            end
            check({tag, " stop bits"}, 64'(stops), 64'd1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic strobe(input logic [63:0] d);
        tdc_data = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        logic [7:0] t1_exp [12];
        logic [7:0] b;
        logic [63:0] y;
        logic [7:0] d_before;
`ifdef TDC_STREAM_POPCOUNT_EN
        t1_exp = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
`else
        t1_exp = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        rst = 1'b1;
        enable = 1'b1;
        data_valid = 1'b1;
        data_valid_w = 1'b0;
        tdc_data = 64'h0000_0000_FFFF_FFFF;

        // 1. reset state and basic frame
        repeat (3) @(negedge clk);
        check("reset uart_tx", 64'(uart_tx), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check("dv in reset ignored", 64'(busy), 64'd0);
        strobe(64'h0000_0000_FFFF_FFFF);
        check("t1 busy after N", 64'(busy), 64'd1);
        check("t1 tx after N", 64'(uart_tx), 64'd1);
        @(negedge clk);
        check("t1 tx after N+1", 64'(uart_tx), 64'd1);
        @(negedge clk);
        check("t1 tx after N+2", 64'(uart_tx), 64'd0);
        wait_bytes(NB, "t1");
        if (rx_q.size() >= NB) begin
            for (int i = 0; i < NB; i++) begin
                b = rx_q.pop_front();
                check($sformatf("t1 byte%0d", i), 64'(b), 64'(t1_exp[i]));
            end
        end
        wait_idle("t1");
        repeat (2) @(negedge clk);
        check("t1 busy length", 64'(busy_last), 64'(NB * 40 + 2));
        stop_q.delete();

        // 2. drops while busy, SEQ increments per completed frame
        do_reset();
        for (int k = 0; k < 3; k++) begin
            strobe(64'h0123_4567_89AB_CDEF);
            repeat (9) @(negedge clk);
        end
        check_frame("t2 f0", 8'h00, 64'h0123_4567_89AB_CDEF);
        check("t2 drop_cnt", 64'(drop_cnt), 64'd2);
        wait_idle("t2");
        strobe(64'h0000_0000_0000_00A5);
        check_frame("t2 f1", 8'h01, 64'h0000_0000_0000_00A5);
        wait_idle("t2b");

        // 3. drop saturation and enable gating
        do_reset();
        tdc_data = 64'hFEDC_BA98_7654_3210;
        data_valid = 1'b1;
        repeat (255) @(negedge clk);
        check("t3 drop 254", 64'(drop_cnt), 64'd254);
        repeat (46) @(negedge clk);
        data_valid = 1'b0;
        check("t3 drop saturated", 64'(drop_cnt), 64'd255);
        check_frame("t3 f0", 8'h00, 64'hFEDC_BA98_7654_3210);
        wait_idle("t3");
        check("t3 drop held", 64'(drop_cnt), 64'd255);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            strobe(64'h5555_5555_5555_5555);
            check($sformatf("t3 disabled busy%0d", k), 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        check("t3 disabled no bytes", 64'(rx_q.size()), 64'd0);
        check("t3 disabled drop", 64'(drop_cnt), 64'd255);
        enable = 1'b1;
        strobe(64'h0F0F_0000_1234_8001);
        enable = 1'b0;
        check_frame("t3 enable drop mid-frame", 8'h01, 64'h0F0F_0000_1234_8001);
        enable = 1'b1;
        wait_idle("t3b");

        // 4. reset during D3 abandons the frame and clears SEQ/drop_cnt
        rx_q.delete();
        stop_q.delete();
        strobe(64'h1122_3344_0055_6677);
        wait_bytes(5, "t4 partial");
        repeat (12) @(negedge clk);
        check("t4 tx in D3", 64'(uart_tx), 64'd0);
        check("t4 busy in D3", 64'(busy), 64'd1);
        rst = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data_valid = 1'b0;
        check("t4 tx after rst", 64'(uart_tx), 64'd1);
        check("t4 busy after rst", 64'(busy), 64'd0);
        check("t4 drop after rst", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        check("t4 dv in rst ignored", 64'(busy), 64'd0);
        repeat (60) @(negedge clk);
        check("t4 partial bytes", 64'(rx_q.size()), 64'd5);
        check("t4 line idle", 64'(uart_tx), 64'd1);
        rx_q.delete();
        stop_q.delete();
        strobe(64'hAAAA_BBBB_CCCC_DDDD);
        check_frame("t4 after rst", 8'h00, 64'hAAAA_BBBB_CCCC_DDDD);
        wait_idle("t4");

        // 6. snapshot hold, final stop-cycle drop, first idle cycle accepted
        do_reset();
        strobe(64'hDEAD_BEEF_CAFE_F00D);
        for (int i = 0; i < 441; i++) begin
            tdc_data = {$urandom, $urandom};
            @(negedge clk);
        end
        check("t6 busy in last stop", 64'(busy), 64'd1);
        tdc_data = 64'h1111_1111_1111_1111;
        data_valid = 1'b1;
        @(negedge clk);
        check("t6 busy fell", 64'(busy), 64'd0);
        check("t6 last-stop drop", 64'(drop_cnt), 64'd1);
        y = 64'h8000_0000_0000_0001;
        tdc_data = y;
        @(negedge clk);
        data_valid = 1'b0;
        check("t6 first idle accepted", 64'(busy), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tdc_data = {$urandom, $urandom};
            @(negedge clk);
        end
        check_frame("t6 held", 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        check_frame("t6 next", 8'h01, y);
        wait_idle("t6");

        // 5. SEQ wrap on the 2-clocks-per-bit instance, reading byte 1 at mid-bit
        for (int k = 0; k < 257; k++) begin
            int t;
            tdc_data = 64'(k);
            data_valid_w = 1'b1;
            @(negedge clk);
            data_valid_w = 1'b0;
            repeat (2) @(negedge clk);
            repeat (21) @(negedge clk);
            d_before = 8'd0;
            for (int i = 0; i < 8; i++) begin
                repeat (2) @(negedge clk);
                d_before[i] = uart_tx_w;
            end
            check($sformatf("t5 seq frame%0d", k), 64'(d_before), 64'(k[7:0]));
            t = 0;
            while (busy_w !== 1'b0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) check("t5 idle timeout", 64'(busy_w), 64'd0);
        end
        check("t5 no drops", 64'(drop_cnt_w), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tdc_uart_streamer.md
# tdc_uart_streamer

Downstream consumer of the TDC sensor's 64-bit thermometer snapshot. On each accepted `data_valid` pulse it freezes `tdc_data` and serialises it as a fixed framed packet over a UART 8N1 line to the host. Single clock domain: the domain in which `tdc_data`/`data_valid` are produced. Captures that arrive while a frame is still being sent are dropped and counted.

## Interface
Parameters:
- `CLK_HZ`, 240_000_000, clock frequency in Hz.
- `BAUD`, 115_200, UART bit rate. `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, must be ≥ 2).

Ports:
- `clk`, in, 1, sample-domain clock.
- `rst`, in, 1, reset; synchronous, active-high.
- `tdc_data`, in, 64, thermometer snapshot; valid only in cycles where `data_valid` is 1.
- `data_valid`, in, 1, single-cycle capture strobe.
- `enable`, in, 1, streaming enable.
- `uart_tx`, out, 1, serial line; idle high.
- `busy`, out, 1, high while a frame is pending or being sent.
- `drop_cnt`, out, 8, saturating count of captures lost to `busy`.

## Operation
- Frame, in byte order: `SYNC` (8'hA5), `SEQ`, `D0`..`D7`, `CHK`. `D0` = `tdc_data[7:0]`, `D7` = `tdc_data[63:56]`. `CHK` = XOR of `SEQ` and `D0`..`D7`; `SYNC` is excluded. This gives 11 bytes.
- Each byte is sent as 8N1: start bit 0, then data LSB first, then stop bit 1. There are no idle gaps between the bytes of a frame.
- States:
  - `IDLE`: on `data_valid && enable`, latch `tdc_data` into the snapshot register and go to `LOAD`.
  - `LOAD`: hand byte index 0 to the transmitter and go to `SEND`.
  - `SEND`: on each byte-done, advance the index. After the last byte's stop bit, go to `IDLE` and increment `SEQ`.
- `SEQ` is 8 bits, starts at 0 and wraps 255→0. It increments only on frame completion.
- Drop rule: `data_valid` with `enable` = 1 in any cycle where state ≠ `IDLE` increments `drop_cnt`. `drop_cnt` saturates at 255.
- `enable` = 0: `data_valid` is ignored and not counted as a drop. Deasserting `enable` mid-frame does not abort the frame; it completes.
- `tdc_data` changing after capture has no effect on the frame in flight.
- `busy` = (state ≠ `IDLE`). A `data_valid` in the final stop-bit cycle is a drop. A `data_valid` in the first `IDLE` cycle after that is accepted.
- Reset at any point, including mid-frame:
  - next edge gives `uart_tx` = 1, `busy` = 0, `drop_cnt` = 0, `SEQ` = 0, state `IDLE`;
  - a partial frame is abandoned without a completing stop bit;
  - `data_valid` in the reset cycle is ignored.

## Timing
- Reset values: `uart_tx` = 1, `busy` = 0, `drop_cnt` = 0.
- All outputs are registered.
- `data_valid` is sampled at edge N. `busy` = 1 after edge N, and `uart_tx` falls (start bit of `SYNC`) after edge N+2.
- Each bit is held for exactly `CLKS_PER_BIT` cycles. Frame length is 110·`CLKS_PER_BIT` cycles, or 120· with the popcount option.
- `busy` falls at the edge ending the last stop bit, so minimum accepted capture spacing is frame length + 2 cycles.
- Transmitter handshake is `tx_valid`/`tx_ready`. `tx_ready` rises in the last cycle of a stop bit, so the next byte's start bit immediately follows.

## Configuration
- `TDC_STREAM_POPCOUNT_EN` defined: a `POP` byte is inserted between `D7` and `CHK`.
  - `POP` = number of 1s in the snapshot, range 0..64.
  - `POP` is included in the `CHK` XOR.
  - Frame is 12 bytes.
- Undefined: 11-byte frame and no popcount logic.

## Structure
- Package `tdc_stream_pkg`:
  - `SYNC_BYTE` (8'hA5);
  - `FRAME_BYTES` (11/12, selected by the macro);
  - state enum `{IDLE, LOAD, SEND}`.
- Sub-module `uart_tx_8n1`, parameterised by `CLKS_PER_BIT`. Ports: `clk`, `rst`, `tx_data[7:0]`, `tx_valid`, `tx_ready`, `tx`.
- Byte mux, checksum, popcount and counters live in the top.

## Test plan
Bench uses `CLK_HZ` = 4_000_000 and `BAUD` = 1_000_000, giving `CLKS_PER_BIT` = 4.
1. Basic frame: reset, then `tdc_data` = 64'h0000_0000_FFFF_FFFF with one `data_valid` → line decodes A5 00 FF FF FF FF 00 00 00 00 00. `uart_tx` falls 2 cycles after the strobe, and `busy` is high for 440+2 cycles. With popcount: A5 00 FF FF FF FF 00 00 00 00 20 20.
2. Drop while busy: three strobes spaced 10 cycles apart → one frame sent and `drop_cnt` = 2. The next accepted frame carries `SEQ` = 01.
3. Saturation and enable: 300 strobes during one frame → `drop_cnt` = 255. With `enable` = 0, strobes produce no frame and no increment.
4. Reset mid-frame: assert `rst` during `D3` → `uart_tx` = 1 next cycle and `busy` = 0. The next frame has `SEQ` = 00.
5. Sequence wrap: 257 well-spaced captures → `SEQ` values run 00..FF, then 00.
6. Snapshot hold: change `tdc_data` every cycle after the strobe → bytes match the value at the strobe edge only, and `CHK` matches.
